csa_seq_subtractor: RTL and testbench

Sequential carry-skip subtractor, the inverse companion to the 8-bit carry-skip adder. It computes diff = a − b − bin one skip block per clock cycle and returns the borrow-out. Operands enter through a valid/ready input handshake, and results leave through a valid/ready output handshake. It sits beside the adder in the arithmetic datapath, where a registered, back-pressurable subtract is needed.

---
 rtl/csa_seq_subtractor.sv | 135 +++++++++++++
 tb/tb_csa_seq_subtractor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/csa_seq_subtractor.sv
// Sequential carry-skip subtractor: diff = a - b - bin, one BLOCK-bit skip block per cycle.
// Latency: out_valid rises NB clock edges after the operand capture edge (2 at defaults).
// Backpressure: result is held while out_valid && !out_ready; in_ready stays low until release.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, bin captured on in_valid && in_ready)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake
//   diff, bout            a - b - bin modulo 2^WIDTH, unsigned borrow-out
//   ovf                   signed overflow, present only when CSS_OVF_EN is defined
//
// Optional feature macro: CSS_OVF_EN (adds the ovf port and its logic).
module csa_seq_subtractor #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = WIDTH / BLOCK;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0]    KLAST = KW'(NB - 1);
  localparam logic [WIDTH-1:0] BMASK = WIDTH'({BLOCK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] dw;      // working difference, slices filled in block order
  logic             c;       // running carry; borrow is its complement
  logic [KW-1:0]    k;

  // Current block datapath
  int               sh;
  logic [BLOCK-1:0] a_k;
  logic [BLOCK-1:0] nb_k;
  logic [BLOCK-1:0] p_k;
  logic [BLOCK:0]   sum_k;
  logic             cout_k;
  logic [WIDTH-1:0] dw_nxt;

  always_comb begin
    sh     = int'(k) * BLOCK;
    a_k    = BLOCK'(a_r >> sh);
    nb_k   = ~BLOCK'(b_r >> sh);
    p_k    = a_k ^ nb_k;
    sum_k  = {1'b0, a_k} + {1'b0, nb_k} + {{BLOCK{1'b0}}, c};
    // Skip path: when every bit propagates, the incoming carry passes straight through.
    cout_k = (&p_k) ? c : sum_k[BLOCK];
    dw_nxt = (dw & ~(BMASK << sh)) | (WIDTH'(sum_k[BLOCK-1:0]) << sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef CSS_OVF_EN
      ovf       <= 1'b0;
`endif
      a_r       <= '0;
      b_r       <= '0;
      dw        <= '0;
      c         <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is always high in IDLE, so in_valid alone completes the handshake
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            c        <= ~bin;   // a - b - bin == a + ~b + ~bin
            k        <= '0;
            dw       <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          dw <= dw_nxt;
          c  <= cout_k;
          if (k == KLAST) begin
            // Outputs only change here, so they stay stable through RUN and DONE
            diff      <= dw_nxt;
            bout      <= ~cout_k;
`ifdef CSS_OVF_EN
            ovf       <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                         (dw_nxt[WIDTH-1] != a_r[WIDTH-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_subtractor.sv
// Directed bench for csa_seq_subtractor: reset, vectors, latency, backpressure, mid-run reset.
// Latency: checks out_valid rises exactly 2 edges after capture.
// Backpressure: holds out_ready low and checks result/in_ready stability.
module tb_csa_seq_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef CSS_OVF_EN
  logic       ovf;
`endif

  int checks;
  int fails;

  csa_seq_subtractor #(.WIDTH(8), .BLOCK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef CSS_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low after out_valid rises
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vbin, input logic [7:0] ed, input logic eb,
                        input logic eo, input int hold);
    int n;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands may change after capture; scramble them
    a   = ~va;
    b   = ~vb;
    bin = ~vbin;
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef CSS_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_diff"}, 32'(diff), 32'(ed));
      check({tag, "_hold_bout"}, 32'(bout), 32'(eb));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_diff_kept"}, 32'(diff), 32'(ed));
    check({tag, "_bout_kept"}, 32'(bout), 32'(eb));
  endtask

  initial begin
    int seen;
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    bin       = 1'b0;

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'h00);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef CSS_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // a, b, bin, diff, bout, ovf, hold
    run_op("basic",   8'hA6, 8'hF5, 1'b0, 8'hB1, 1'b1, 1'b0, 0);
    run_op("sovf",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op("bin",     8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("skip0",   8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run_op("skip1",   8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("bp",      8'h3C, 8'h1E, 1'b0, 8'h1E, 1'b0, 1'b0, 5);

    // Reset one cycle after capture
    @(negedge clk);
    a        = 8'hC3;
    b        = 8'h21;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    check("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
    run_op("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global guard so the bench always terminates
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
